mesh_adapter_match_pe: RTL and testbench

- Responder end of the shared-match-PE mesh protocol; the counterpart of the job-PE-side mesh adapter.
- Accepts match-request packets arriving from the mesh and issues them to one local shared match_pe.
- Returns each match_pe response to the originating job PE over the mesh, using source coordinates it has recorded.
- One instance per shared match_pe, between the mesh router port and match_pe.

---
 rtl/mesh_adapter_match_pe.sv | 177 +++++++++++++++++
 tb/tb_mesh_adapter_match_pe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_adapter_match_pe.sv
// Responder-side mesh adapter for one shared match_pe.
// Requests from the mesh are registered and issued to match_pe; their
// source coordinates wait in a FIFO. Each in-order match_pe response is
// matched with the FIFO head and sent back to its job PE.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 4
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 8
`endif
`ifndef MESH_X_SIZE_LOG2
`define MESH_X_SIZE_LOG2 2
`endif
`ifndef MESH_Y_SIZE_LOG2
`define MESH_Y_SIZE_LOG2 2
`endif
`ifndef MESH_W
`define MESH_W 64
`endif

module mesh_adapter_match_pe #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_BITS        = `LAZY_LEN_LOG2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         from_mesh_valid,
  output logic                         from_mesh_ready,
  input  logic [`MESH_W-1:0]           from_mesh_payload,
  output logic                         match_req_valid,
  input  logic                         match_req_ready,
  output logic [TAG_BITS-1:0]          match_req_tag,
  output logic [`ADDR_WIDTH-1:0]       match_req_head_addr,
  output logic [`ADDR_WIDTH-1:0]       match_req_history_addr,
  input  logic                         match_resp_valid,
  output logic                         match_resp_ready,
  input  logic [TAG_BITS-1:0]          match_resp_tag,
  input  logic [`MATCH_LEN_WIDTH-1:0]  match_resp_match_len,
  output logic                         to_mesh_valid,
  input  logic                         to_mesh_ready,
  output logic [`MESH_X_SIZE_LOG2-1:0] to_mesh_x_dst,
  output logic [`MESH_Y_SIZE_LOG2-1:0] to_mesh_y_dst,
  output logic [`MESH_W-1:0]           to_mesh_payload
);
  localparam int AW = `ADDR_WIDTH;
  localparam int XW = `MESH_X_SIZE_LOG2;
  localparam int YW = `MESH_Y_SIZE_LOG2;
  localparam int MW = `MESH_W;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int HEAD_LSB = AW;
  localparam int TAG_LSB  = 2 * AW;
  localparam int Y_LSB    = TAG_LSB + TAG_BITS;
  localparam int X_LSB    = Y_LSB + YW;
  localparam int REQ_BITS = X_LSB + XW;

  logic                r_req_valid;
  logic [TAG_BITS-1:0] r_req_tag;
  logic [AW-1:0]       r_req_head;
  logic [AW-1:0]       r_req_hist;
  logic [CW-1:0]       r_inflight;
  logic [XW-1:0]       r_src_x [MAX_OUTSTANDING];
  logic [YW-1:0]       r_src_y [MAX_OUTSTANDING];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_resp_valid;
  logic [MW-1:0]       r_resp_pay;
  logic [XW-1:0]       r_x_dst;
  logic [YW-1:0]       r_y_dst;

  logic w_in_fire, w_req_fire, w_resp_fire, w_out_fire, w_fifo_nempty;
  logic w_unused_pay;

  assign w_fifo_nempty = (r_count != '0);
  assign w_unused_pay  = ^from_mesh_payload[MW-1:REQ_BITS];

  assign from_mesh_ready  = (r_inflight < CW'(MAX_OUTSTANDING)) &&
                            (!r_req_valid || match_req_ready);
  assign match_resp_ready = (!r_resp_valid || to_mesh_ready) && w_fifo_nempty;

  assign w_in_fire   = from_mesh_valid && from_mesh_ready;
  assign w_req_fire  = r_req_valid && match_req_ready;
  assign w_resp_fire = match_resp_valid && match_resp_ready;
  assign w_out_fire  = r_resp_valid && to_mesh_ready;

  assign match_req_valid        = r_req_valid;
  assign match_req_tag          = r_req_tag;
  assign match_req_head_addr    = r_req_head;
  assign match_req_history_addr = r_req_hist;
  assign to_mesh_valid          = r_resp_valid;
  assign to_mesh_x_dst          = r_x_dst;
  assign to_mesh_y_dst          = r_y_dst;
  assign to_mesh_payload        = r_resp_pay;

  // Ingress stage: capture request fields, hold until match_pe takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_tag   <= '0;
      r_req_head  <= '0;
      r_req_hist  <= '0;
    end else if (w_in_fire) begin
      r_req_valid <= 1'b1;
      r_req_tag   <= from_mesh_payload[TAG_LSB +: TAG_BITS];
      r_req_head  <= from_mesh_payload[HEAD_LSB +: AW];
      r_req_hist  <= from_mesh_payload[0 +: AW];
    end else if (w_req_fire) begin
      r_req_valid <= 1'b0;
    end
  end

  // Requests accepted but whose response has not yet left on the mesh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= '0;
    else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Source FIFO: pushed on accept, popped when the matching response loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_src_x[i] <= '0;
        r_src_y[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_in_fire) begin
        r_src_x[r_wr_ptr] <= from_mesh_payload[X_LSB +: XW];
        r_src_y[r_wr_ptr] <= from_mesh_payload[Y_LSB +: YW];
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_resp_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_in_fire, w_resp_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Egress stage: pair the response with its recorded source, hold for the mesh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_pay   <= '0;
      r_x_dst      <= '0;
      r_y_dst      <= '0;
    end else if (w_resp_fire) begin
      r_resp_valid <= 1'b1;
      r_resp_pay   <= MW'({match_resp_tag, match_resp_match_len});
      r_x_dst      <= r_src_x[r_rd_ptr];
      r_y_dst      <= r_src_y[r_rd_ptr];
    end else if (w_out_fire) begin
      r_resp_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // match_pe must never answer when no request is waiting for a response
  a_resp_has_src: assert property (@(posedge clk) disable iff (!rst_n)
                                   match_resp_valid |-> w_fifo_nempty)
    else $error("mesh_adapter_match_pe: match_resp_valid with empty source FIFO");
`endif

endmodule

// File: tb/tb_mesh_adapter_match_pe.sv
// Bench for mesh_adapter_match_pe: directed table, hand sequences and
// random traffic checked against a transaction-level queue model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef LAZY_LEN_LOG2
`define LAZY_LEN_LOG2 4
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 8
`endif
`ifndef MESH_X_SIZE_LOG2
`define MESH_X_SIZE_LOG2 2
`endif
`ifndef MESH_Y_SIZE_LOG2
`define MESH_Y_SIZE_LOG2 2
`endif
`ifndef MESH_W
`define MESH_W 64
`endif

module tb_mesh_adapter_match_pe;
  localparam int MAXO = 4;
  localparam int TBW  = `LAZY_LEN_LOG2;
  localparam int AW   = `ADDR_WIDTH;
  localparam int ML   = `MATCH_LEN_WIDTH;
  localparam int XW   = `MESH_X_SIZE_LOG2;
  localparam int YW   = `MESH_Y_SIZE_LOG2;
  localparam int MW   = `MESH_W;

  logic clk, rst_n;
  logic from_mesh_valid, from_mesh_ready;
  logic [MW-1:0] from_mesh_payload;
  logic match_req_valid, match_req_ready;
  logic [TBW-1:0] match_req_tag;
  logic [AW-1:0] match_req_head_addr, match_req_history_addr;
  logic match_resp_valid, match_resp_ready;
  logic [TBW-1:0] match_resp_tag;
  logic [ML-1:0] match_resp_match_len;
  logic to_mesh_valid, to_mesh_ready;
  logic [XW-1:0] to_mesh_x_dst;
  logic [YW-1:0] to_mesh_y_dst;
  logic [MW-1:0] to_mesh_payload;

  mesh_adapter_match_pe #(.MAX_OUTSTANDING(MAXO), .TAG_BITS(TBW)) dut (
    .clk(clk), .rst_n(rst_n),
    .from_mesh_valid(from_mesh_valid), .from_mesh_ready(from_mesh_ready),
    .from_mesh_payload(from_mesh_payload),
    .match_req_valid(match_req_valid), .match_req_ready(match_req_ready),
    .match_req_tag(match_req_tag), .match_req_head_addr(match_req_head_addr),
    .match_req_history_addr(match_req_history_addr),
    .match_resp_valid(match_resp_valid), .match_resp_ready(match_resp_ready),
    .match_resp_tag(match_resp_tag), .match_resp_match_len(match_resp_match_len),
    .to_mesh_valid(to_mesh_valid), .to_mesh_ready(to_mesh_ready),
    .to_mesh_x_dst(to_mesh_x_dst), .to_mesh_y_dst(to_mesh_y_dst),
    .to_mesh_payload(to_mesh_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] pack_req(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                             input logic [TBW-1:0] t, input logic [AW-1:0] h,
                                             input logic [AW-1:0] hi);
    return MW'(hi) | (MW'(h) << AW) | (MW'(t) << (2*AW)) |
           (MW'(y) << (2*AW+TBW)) | (MW'(x) << (2*AW+TBW+YW));
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef struct { logic [TBW-1:0] tag; logic [AW-1:0] head, hist; } req_t;
  typedef struct { logic [TBW-1:0] tag; logic [ML-1:0] len; } pe_t;
  typedef struct { logic [XW-1:0] x; logic [YW-1:0] y; logic [TBW-1:0] tag; logic [ML-1:0] len; } out_t;

  req_t              reqq[$];   // accepted, not yet taken by match_pe
  pe_t               peq[$];    // inside match_pe, awaiting response
  logic [XW+YW-1:0]  srcq[$];   // sources whose response has not been paired
  out_t              outq[$];   // paired responses awaiting the mesh
  int infl = 0;
  int n_acc = 0;
  int n_emit = 0;

  task automatic model_clear();
    reqq.delete(); peq.delete(); srcq.delete(); outq.delete();
    infl = 0;
  endtask

  // One clock: drive at negedge, check 1ns later, advance model at posedge
  task automatic run_cycle(input bit fv, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [TBW-1:0] t, input logic [AW-1:0] h,
                           input logic [AW-1:0] hi, input bit junk,
                           input bit mrr, input bit rsp_en, input bit tmr);
    bit e_mrv, e_fmr, e_tmv, e_mrr, f_in, f_req, f_resp, f_out;
    req_t r; pe_t p; out_t o; logic [XW+YW-1:0] s;
    from_mesh_valid   = fv;
    from_mesh_payload = pack_req(x, y, t, h, hi) | (junk ? (MW'($urandom) << 48) : '0);
    match_req_ready   = mrr;
    match_resp_valid  = rsp_en && (peq.size() > 0);
    match_resp_tag    = (peq.size() > 0) ? peq[0].tag : '0;
    match_resp_match_len = (peq.size() > 0) ? peq[0].len : '0;
    to_mesh_ready     = tmr;
    #1;
    e_mrv = reqq.size() > 0;
    e_fmr = (infl < MAXO) && (!e_mrv || mrr);
    e_tmv = outq.size() > 0;
    e_mrr = (!e_tmv || tmr) && (srcq.size() > 0);
    chk("from_mesh_ready", 64'(from_mesh_ready), 64'(e_fmr));
    chk("match_req_valid", 64'(match_req_valid), 64'(e_mrv));
    if (e_mrv) begin
      chk("match_req_tag",  64'(match_req_tag), 64'(reqq[0].tag));
      chk("match_req_head", 64'(match_req_head_addr), 64'(reqq[0].head));
      chk("match_req_hist", 64'(match_req_history_addr), 64'(reqq[0].hist));
    end
    chk("match_resp_ready", 64'(match_resp_ready), 64'(e_mrr));
    chk("to_mesh_valid", 64'(to_mesh_valid), 64'(e_tmv));
    if (e_tmv) begin
      chk("to_mesh_x_dst", 64'(to_mesh_x_dst), 64'(outq[0].x));
      chk("to_mesh_y_dst", 64'(to_mesh_y_dst), 64'(outq[0].y));
      chk("to_mesh_payload", 64'(to_mesh_payload),
          64'(MW'(outq[0].len) | (MW'(outq[0].tag) << ML)));
    end
    f_in   = fv && e_fmr;
    f_req  = e_mrv && mrr;
    f_resp = match_resp_valid && e_mrr;
    f_out  = e_tmv && tmr;
    @(posedge clk);
    if (f_out) begin void'(outq.pop_front()); infl--; n_emit++; end
    if (f_resp) begin
      s = srcq.pop_front(); p = peq.pop_front();
      o.x = s[XW+YW-1:YW]; o.y = s[YW-1:0]; o.tag = p.tag; o.len = p.len;
      outq.push_back(o);
    end
    if (f_req) begin
      r = reqq.pop_front();
      p.tag = r.tag; p.len = ML'($urandom);
      peq.push_back(p);
    end
    if (f_in) begin
      r.tag = t; r.head = h; r.hist = hi;
      reqq.push_back(r); srcq.push_back({x, y}); infl++; n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    from_mesh_valid = 0; from_mesh_payload = '0; match_req_ready = 0;
    match_resp_valid = 0; match_resp_tag = '0; match_resp_match_len = '0;
    to_mesh_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n, input bit toggle);
    for (int i = 0; i < n; i++)
      run_cycle(0, '0, '0, '0, '0, '0, 0, 1, 1, toggle ? bit'(i % 2) : 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit fv; logic [XW-1:0] x; logic [YW-1:0] y; logic [TBW-1:0] t; logic [AW-1:0] h, hi;
    bit mrr, rv; logic [TBW-1:0] rt; logic [ML-1:0] rl; bit tmr;
    bit e_fmr, e_mrv, rchk; logic [TBW-1:0] e_t; logic [AW-1:0] e_h, e_hi;
    bit e_mrr, e_tmv, ochk; logic [XW-1:0] e_x; logic [YW-1:0] e_y; logic [MW-1:0] e_pay;
  } row_t;
  row_t tbl[8];

  initial begin
    int cyc;
    // reset state, then single request (2,1) tag 3, head 0x100, hist 0x40, len 17
    tbl[0] = '{0,0,0,0,0,0,     0,0,0,0, 0,  1,0,1,0,0,0,      0,0,1,0,0,0};
    tbl[1] = '{1,2,1,3,'h100,'h40, 0,0,0,0, 0, 1,0,1,0,0,0,      0,0,1,0,0,0};
    tbl[2] = '{0,0,0,0,0,0,     1,0,0,0, 0,  1,1,1,3,'h100,'h40, 1,0,1,0,0,0};
    tbl[3] = '{0,0,0,0,0,0,     1,1,3,17,0,  1,0,0,0,0,0,        1,0,1,0,0,0};
    tbl[4] = '{0,0,0,0,0,0,     0,0,0,0, 0,  1,0,0,0,0,0,        0,1,1,2,1,'h311};
    tbl[5] = '{0,0,0,0,0,0,     0,0,0,0, 0,  1,0,0,0,0,0,        0,1,1,2,1,'h311};
    tbl[6] = '{0,0,0,0,0,0,     0,0,0,0, 1,  1,0,0,0,0,0,        0,1,1,2,1,'h311};
    tbl[7] = '{0,0,0,0,0,0,     0,0,0,0, 0,  1,0,0,0,0,0,        0,0,0,0,0,0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      from_mesh_valid = tbl[i].fv;
      from_mesh_payload = pack_req(tbl[i].x, tbl[i].y, tbl[i].t, tbl[i].h, tbl[i].hi);
      match_req_ready = tbl[i].mrr;
      match_resp_valid = tbl[i].rv; match_resp_tag = tbl[i].rt; match_resp_match_len = tbl[i].rl;
      to_mesh_ready = tbl[i].tmr;
      #1;
      chk($sformatf("tbl%0d from_mesh_ready", i), 64'(from_mesh_ready), 64'(tbl[i].e_fmr));
      chk($sformatf("tbl%0d match_req_valid", i), 64'(match_req_valid), 64'(tbl[i].e_mrv));
      if (tbl[i].rchk) begin
        chk($sformatf("tbl%0d match_req_tag", i), 64'(match_req_tag), 64'(tbl[i].e_t));
        chk($sformatf("tbl%0d match_req_head", i), 64'(match_req_head_addr), 64'(tbl[i].e_h));
        chk($sformatf("tbl%0d match_req_hist", i), 64'(match_req_history_addr), 64'(tbl[i].e_hi));
      end
      chk($sformatf("tbl%0d match_resp_ready", i), 64'(match_resp_ready), 64'(tbl[i].e_mrr));
      chk($sformatf("tbl%0d to_mesh_valid", i), 64'(to_mesh_valid), 64'(tbl[i].e_tmv));
      if (tbl[i].ochk) begin
        chk($sformatf("tbl%0d to_mesh_x_dst", i), 64'(to_mesh_x_dst), 64'(tbl[i].e_x));
        chk($sformatf("tbl%0d to_mesh_y_dst", i), 64'(to_mesh_y_dst), 64'(tbl[i].e_y));
        chk($sformatf("tbl%0d to_mesh_payload", i), 64'(to_mesh_payload), 64'(tbl[i].e_pay));
      end
      @(negedge clk);
    end

    // back-pressure limit: match_pe takes requests but withholds responses
    do_reset();
    for (int i = 0; i < 6; i++)
      run_cycle(1, XW'(i), YW'(i), TBW'(i), AW'(16*i), AW'(i), 0, 1, 0, 1);
    from_mesh_valid = 1; #1;
    chk("limit_blocks_ready", 64'(from_mesh_ready), 64'(0));
    @(negedge clk);
    drain(12, 0);

    // four sources, in-order responses, mesh ready toggling
    run_cycle(1, 0, 0, 1, 'h10, 'h01, 0, 1, 1, 0);
    run_cycle(1, 1, 0, 2, 'h20, 'h02, 0, 1, 1, 1);
    run_cycle(1, 0, 1, 3, 'h30, 'h03, 0, 1, 1, 0);
    run_cycle(1, 1, 1, 4, 'h40, 'h04, 0, 1, 1, 1);
    drain(16, 1);

    // mesh stall with two responses queued, then release
    run_cycle(1, 3, 2, 5, 'h50, 'h05, 0, 1, 1, 0);
    run_cycle(1, 2, 3, 6, 'h60, 'h06, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++)
      run_cycle(0, '0, '0, '0, '0, '0, 0, 1, 1, 0);
    drain(6, 0);

    // streaming: 100 requests with every ready high
    begin
      int base_a, base_e;
      base_a = n_acc; base_e = n_emit; cyc = 0;
      while (n_emit < base_e + 100 && cyc < 300) begin
        run_cycle(n_acc < base_a + 100, XW'($urandom), YW'($urandom), TBW'($urandom),
                  AW'($urandom), AW'($urandom), 1, 1, 1, 1);
        cyc++;
      end
      chk("stream_cycles", 64'(cyc), 64'(103));
    end
    from_mesh_valid = 0; to_mesh_ready = 1; #1;
    chk("stream_idle_ready", 64'(from_mesh_ready), 64'(1));
    chk("stream_idle_valid", 64'(to_mesh_valid), 64'(0));
    @(negedge clk);

    // random traffic
    for (int i = 0; i < 600; i++)
      run_cycle(bit'($urandom_range(0, 1)), XW'($urandom), YW'($urandom), TBW'($urandom),
                AW'($urandom), AW'($urandom), 1, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    drain(20, 0);

    // reset with three requests in flight
    for (int i = 0; i < 3; i++)
      run_cycle(1, XW'(i), YW'(i+1), TBW'(i+7), AW'(i), AW'(i), 0, 1, 0, 0);
    rst_n = 1'b0; #1;
    chk("rst_from_mesh_ready", 64'(from_mesh_ready), 64'(1));
    chk("rst_match_req_valid", 64'(match_req_valid), 64'(0));
    chk("rst_match_resp_ready", 64'(match_resp_ready), 64'(0));
    chk("rst_to_mesh_valid", 64'(to_mesh_valid), 64'(0));
    idle_inputs();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(1, 3, 3, 9, 'h1234, 'h0567, 0, 1, 1, 1);
    drain(6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
